// File: rtl/dec_scan_n.sv
// dec_scan_n: parametrised N-to-2^N decoder with registered one-hot (or
// one-cold) outputs. Direct mode decodes the select input one clock later;
// scan mode walks the outputs from index 0 up to 'last' at a prescaled rate,
// for digit or row multiplexing of downstream banks.
module dec_scan_n #(
  parameter int N          = 3,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      last,
  output logic [(1<<N)-1:0] D,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 1 << N;
  // A DIV of 1 still gets a one-bit prescaler; it simply never counts.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  INACTIVE = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

  logic [W-1:0]  d_q,    d_n;
  logic [N-1:0]  idx_q,  idx_n;
  logic          wrap_q, wrap_n;
  logic [PW-1:0] pre_q,  pre_n;
  logic          mode_q, mode_n;

  // One-hot image of an index, before polarity is applied.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Apply the output polarity: active-low banks see the one-cold inverse.
  function automatic logic [W-1:0] polar(input logic [W-1:0] v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  // Next-state selection: enable freezes everything except the outputs,
  // which go inactive; otherwise direct decode, scan entry, or scan step.
  // D is always derived from the next index so D and idx can never skew.
  always_comb begin
    idx_n  = idx_q;
    pre_n  = pre_q;
    mode_n = mode_q;
    wrap_n = 1'b0;
    d_n    = INACTIVE;

    if (en) begin
      mode_n = mode;
      if (!mode) begin
        idx_n = A;
        pre_n = '0;
      end else if (!mode_q) begin
        idx_n = '0;
        pre_n = '0;
      end else if (pre_q == PRE_LAST) begin
        pre_n = '0;
        // Using >= means a shrunken 'last' below the current index wraps
        // on the next step instead of climbing past the new limit.
        if (idx_q >= last) begin
          idx_n  = '0;
          wrap_n = 1'b1;
        end else begin
          idx_n = idx_q + N'(1);
        end
      end else begin
        pre_n = pre_q + PW'(1);
      end
      d_n = polar(onehot(idx_n));
    end
  end

  // State and output registers with asynchronous return to the idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= INACTIVE;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      pre_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      d_q    <= d_n;
      idx_q  <= idx_n;
      wrap_q <= wrap_n;
      pre_q  <= pre_n;
      mode_q <= mode_n;
    end
  end

  assign D    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Scoreboard bench for dec_scan_n: two instances (active-high DIV=4 and
// active-low DIV=1). Stimulus pushes the expected registered response for
// each edge; a monitor pops and compares just after every rising edge.
module tb_dec_scan_n;

  logic       clk;
  logic       rst;
  logic       en, mode;
  logic [2:0] a, last;
  logic [7:0] d;
  logic [2:0] idx;
  logic       wrap;
  logic       en2, mode2;
  logic [2:0] a2, last2;
  logic [7:0] d2;
  logic [2:0] idx2;
  logic       wrap2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         which;
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  dec_scan_n #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .A(a), .last(last),
    .D(d), .idx(idx), .wrap(wrap)
  );

  dec_scan_n #(.N(3), .DIV(1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .A(a2), .last(last2),
    .D(d2), .idx(idx2), .wrap(wrap2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.which) begin
      checkValue("al.D",    d2,           e.d);
      checkValue("al.idx",  {5'd0, idx2}, {5'd0, e.idx});
      checkValue("al.wrap", {7'd0, wrap2}, {7'd0, e.wrap});
    end else begin
      checkValue("D",    d,            e.d);
      checkValue("idx",  {5'd0, idx},  {5'd0, e.idx});
      checkValue("wrap", {7'd0, wrap}, {7'd0, e.wrap});
    end
  endtask

  // Drive one instance's inputs for the coming edge and queue its response.
  task automatic applyStimulus(input bit which, input logic e, input logic m,
                               input logic [2:0] sel, input logic [2:0] lst,
                               input logic [7:0] exp_d, input logic [2:0] exp_idx,
                               input logic exp_wrap);
    exp_t x;
    if (which) begin
      en2 = e; mode2 = m; a2 = sel; last2 = lst;
    end else begin
      en = e; mode = m; a = sel; last = lst;
    end
    x.which = which;
    x.d     = exp_d;
    x.idx   = exp_idx;
    x.wrap  = exp_wrap;
    sb.push_back(x);
  endtask

  // Monitor: compare each queued response just after the edge it belongs to.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    logic [7:0] one;
    logic [2:0] ei;
    logic       ew;
    one = 8'h01;
    rst = 1'b1;
    en = 1'b0; mode = 1'b0; a = 3'd0; last = 3'd0;
    en2 = 1'b0; mode2 = 1'b0; a2 = 3'd0; last2 = 3'd0;

    // Reset values
    #3;
    checkValue("rst.D",     d,     8'h00);
    checkValue("rst.idx",   {5'd0, idx},  8'h00);
    checkValue("rst.wrap",  {7'd0, wrap}, 8'h00);
    checkValue("rst.al.D",  d2,    8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Direct sweep: D follows A one clock later
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(0, 1, 0, 3'(i), 3'd7, one << i, 3'(i), 0);
    end

    // Full scan, last=7: 4 clocks per index, wrap every 32 clocks
    for (int c = 0; c < 64; c++) begin
      ei = 3'((c / 4) % 8);
      ew = (c % 32 == 0) && (c > 0);
      @(negedge clk);
      applyStimulus(0, 1, 1, 3'd0, 3'd7, one << ei, ei, ew);
    end

    // Back to direct for one clock, then partial scan with last shrinking 2->1
    @(negedge clk);
    applyStimulus(0, 1, 0, 3'd0, 3'd2, 8'h01, 3'd0, 0);
    for (int c = 0; c < 52; c++) begin
      if (c < 36) begin
        ei = 3'((c / 4) % 3);
        ew = (c % 12 == 0) && (c > 0);
      end else begin
        ei = 3'(((c - 36) / 4) % 2);
        ew = (c % 4 == 0) && (ei == 3'd0);
      end
      @(negedge clk);
      applyStimulus(0, 1, 1, 3'd0, (c < 34) ? 3'd2 : 3'd1, one << ei, ei, ew);
    end

    // Enable freeze mid-step: prescaler held at 1 while en is low
    @(negedge clk);
    applyStimulus(0, 1, 0, 3'd0, 3'd7, 8'h01, 3'd0, 0);
    for (int c = 0; c < 6; c++) begin
      ei = 3'(c / 4);
      @(negedge clk);
      applyStimulus(0, 1, 1, 3'd0, 3'd7, one << ei, ei, 0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1, 3'd0, 3'd7, 8'h00, 3'd1, 0);
    end
    for (int r = 0; r < 9; r++) begin
      ei = (r < 2) ? 3'd1 : ((r < 6) ? 3'd2 : 3'd3);
      @(negedge clk);
      applyStimulus(0, 1, 1, 3'd0, 3'd7, one << ei, ei, 0);
    end

    // Asynchronous reset between edges, then restart from index 0
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkValue("arst.D",    d,            8'h00);
    checkValue("arst.idx",  {5'd0, idx},  8'h00);
    checkValue("arst.wrap", {7'd0, wrap}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 1, 3'd0, 3'd7, 8'h01, 3'd0, 0);
    for (int c = 1; c < 9; c++) begin
      ei = 3'(c / 4);
      @(negedge clk);
      applyStimulus(0, 1, 1, 3'd0, 3'd7, one << ei, ei, 0);
    end
    @(negedge clk);
    applyStimulus(0, 0, 1, 3'd0, 3'd7, 8'h00, 3'd2, 0);

    // Active-low, DIV=1, last=3: FE FD FB F7 FE ... on consecutive clocks
    for (int c = 0; c < 10; c++) begin
      ei = 3'(c % 4);
      ew = (c % 4 == 0) && (c > 0);
      @(negedge clk);
      applyStimulus(1, 1, 1, 3'd0, 3'd3, ~(one << ei), ei, ew);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      applyStimulus(1, 0, 1, 3'd0, 3'd3, 8'hFF, 3'd1, 0);
    end
    @(negedge clk);
    applyStimulus(1, 1, 0, 3'd5, 3'd3, 8'hDF, 3'd5, 0);

    // Let the monitor drain the queue, bounded
    repeat (3) @(posedge clk);
    #2;
    checkValue("drain", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
